// File: rtl/sram_arb_pkg.sv
// Shared types and defaults for the SRAM arbiter.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    typedef enum logic {
        PORT_CPU = 1'b0,
        PORT_LD  = 1'b1
    } port_e;

    localparam int unsigned WAIT_CYCLES_DEF = 2;

endpackage

// File: rtl/sram_arbiter_if.sv
// Requester ports (CPU and loader) plus the board SRAM pins, bundled for the arbiter.
interface sram_arbiter_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_ack;

    logic              ld_req;
    logic              ld_we;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_wdata;
    logic [DATA_W-1:0] ld_rdata;
    logic              ld_ack;

    logic [ADDR_W-1:0] ADDR;
    logic [DATA_W-1:0] Data_to_SRAM;
    logic [DATA_W-1:0] Data_from_SRAM;
    logic              OE;
    logic              WE;
    logic              busy;
    logic              grant;

    // Arbiter side.
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ack,
        input  ld_req, ld_we, ld_addr, ld_wdata,
        output ld_rdata, ld_ack,
        output ADDR, Data_to_SRAM, OE, WE, busy, grant,
        input  Data_from_SRAM
    );

    // Requester / board side.
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ack,
        output ld_req, ld_we, ld_addr, ld_wdata,
        input  ld_rdata, ld_ack,
        input  ADDR, Data_to_SRAM, OE, WE, busy, grant,
        output Data_from_SRAM
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-input round-robin picker: a sole requester wins, a tie goes to the port not granted last.
module rr_arb2
    import sram_arb_pkg::*;
(
    input  logic [1:0] req_i,        // bit 0 = CPU, bit 1 = loader
    input  port_e      last_grant_i,
    output port_e      winner_o
);

    // Pick the winner; with no request the output is a don't-care (CPU).
    always_comb begin
        winner_o = PORT_CPU;
        case (req_i)
            2'b10:   winner_o = PORT_LD;
            2'b11:   winner_o = (last_grant_i == PORT_LD) ? PORT_CPU : PORT_LD;
            default: winner_o = PORT_CPU;
        endcase
    end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one asynchronous SRAM between the CPU and the loader with fixed wait states.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEF,
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DATA_W      = 16
) (
    input logic           Clk,
    input logic           Reset,
    sram_arbiter_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(WAIT_CYCLES + 1);

    state_e            state_q, state_d;
    port_e             grant_q, grant_d;
    port_e             last_grant_q, last_grant_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              oe_n_q, oe_n_d;
    logic              we_n_q, we_n_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] ld_rdata_q, ld_rdata_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              ld_ack_q, ld_ack_d;

    port_e             winner;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    rr_arb2 u_rr_arb2 (
        .req_i        ({bus.ld_req, bus.cpu_req}),
        .last_grant_i (last_grant_q),
        .winner_o     (winner)
    );

    // Route the winning requester's command toward the latch registers.
    always_comb begin
        sel_we    = bus.cpu_we;
        sel_addr  = bus.cpu_addr;
        sel_wdata = bus.cpu_wdata;
        if (winner == PORT_LD) begin
            sel_we    = bus.ld_we;
            sel_addr  = bus.ld_addr;
            sel_wdata = bus.ld_wdata;
        end
    end

    // FSM next state: latch in IDLE, count wait states in ACCESS, acknowledge in DONE.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        oe_n_d       = oe_n_q;
        we_n_d       = we_n_q;
        cpu_rdata_d  = cpu_rdata_q;
        ld_rdata_d   = ld_rdata_q;
        cpu_ack_d    = 1'b0;
        ld_ack_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.cpu_req || bus.ld_req) begin
                    grant_d      = winner;
                    last_grant_d = winner;
                    we_d         = sel_we;
                    addr_d       = sel_addr;
                    wdata_d      = sel_wdata;
                    cnt_d        = CNT_W'(WAIT_CYCLES - 1);
                    oe_n_d       = sel_we;
                    we_n_d       = ~sel_we;
                    state_d      = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    if (!we_q) begin
                        if (grant_q == PORT_LD) ld_rdata_d = bus.Data_from_SRAM;
                        else                    cpu_rdata_d = bus.Data_from_SRAM;
                    end
                    // Strobes release here so they stay low exactly WAIT_CYCLES cycles.
                    oe_n_d    = 1'b1;
                    we_n_d    = 1'b1;
                    cpu_ack_d = (grant_q == PORT_CPU);
                    ld_ack_d  = (grant_q == PORT_LD);
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // All state and every output register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q      <= IDLE;
            grant_q      <= PORT_CPU;
            last_grant_q <= PORT_LD;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cnt_q        <= '0;
            oe_n_q       <= 1'b1;
            we_n_q       <= 1'b1;
            cpu_rdata_q  <= '0;
            ld_rdata_q   <= '0;
            cpu_ack_q    <= 1'b0;
            ld_ack_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            oe_n_q       <= oe_n_d;
            we_n_q       <= we_n_d;
            cpu_rdata_q  <= cpu_rdata_d;
            ld_rdata_q   <= ld_rdata_d;
            cpu_ack_q    <= cpu_ack_d;
            ld_ack_q     <= ld_ack_d;
        end
    end

    assign bus.ADDR         = addr_q;
    assign bus.Data_to_SRAM = wdata_q;
    assign bus.OE           = oe_n_q;
    assign bus.WE           = we_n_q;
    assign bus.cpu_rdata    = cpu_rdata_q;
    assign bus.ld_rdata     = ld_rdata_q;
    assign bus.cpu_ack      = cpu_ack_q;
    assign bus.ld_ack       = ld_ack_q;
    assign bus.busy         = (state_q != IDLE);
    assign bus.grant        = (grant_q == PORT_LD);

endmodule

// File: tb/tb_sram_arbiter.sv
// Randomized bench for sram_arbiter against a transaction-level model of the arbiter and SRAM.
module tb_sram_arbiter;
    import sram_arb_pkg::*;

    localparam int unsigned W = 2;

    logic Clk   = 1'b0;
    logic Reset = 1'b1;

    sram_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    sram_arbiter #(.WAIT_CYCLES(W), .ADDR_W(16), .DATA_W(16)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    function automatic logic [15:0] init_val(input logic [7:0] a);
        return {a, ~a} ^ 16'h5A3C;
    endfunction

    // Board SRAM model: 256 words aliased on ADDR[7:0], drives only while OE is low.
    logic [15:0] mem [256];
    logic        mem_init = 1'b0;
    always @(posedge Clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_val(8'(i));
            mem_init <= 1'b1;
        end else if (!bus.WE) begin
            mem[bus.ADDR[7:0]] <= bus.Data_to_SRAM;
        end
    end
    assign bus.Data_from_SRAM = bus.OE ? 16'hDEAD : mem[bus.ADDR[7:0]];

    // Reference state: expected memory contents, rdata registers and last winner.
    logic [15:0] ref_mem [256];
    logic [15:0] exp_rd [2];
    int          last_win;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int p, input logic req, input logic we,
                         input logic [15:0] a, input logic [15:0] d);
        if (p == 0) begin
            bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
        end else begin
            bus.ld_req = req; bus.ld_we = we; bus.ld_addr = a; bus.ld_wdata = d;
        end
    endtask

    // One round: chosen ports raise req together from idle, each holds until its ack.
    task automatic do_round(input bit use_c, input logic we_c, input logic [15:0] a_c,
                            input logic [15:0] d_c, input bit use_l, input logic we_l,
                            input logic [15:0] a_l, input logic [15:0] d_l);
        bit          use_p [2];
        logic        w [2];
        logic [15:0] a [2];
        logic [15:0] d [2];
        int          order [2];
        int          n, served, cur, oe_cnt, we_cnt;
        use_p[0] = use_c; w[0] = we_c; a[0] = a_c; d[0] = d_c;
        use_p[1] = use_l; w[1] = we_l; a[1] = a_l; d[1] = d_l;
        if (use_c && use_l) begin
            order[0] = (last_win == 1) ? 0 : 1;
            order[1] = 1 - order[0];
            n = 2;
        end else begin
            order[0] = use_c ? 0 : 1;
            order[1] = order[0];
            n = 1;
        end
        @(negedge Clk);
        for (int p = 0; p < 2; p++) if (use_p[p]) drive(p, 1'b1, w[p], a[p], d[p]);
        served = 0; oe_cnt = 0; we_cnt = 0;
        for (int c = 1; c <= 3 * (W + 2) + 4 && served < n; c++) begin
            @(negedge Clk);
            cur = order[served];
            if (c == 1) begin
                check("busy_after_grant", bus.busy, 1);
                check("grant_first", bus.grant, cur);
                // Requester moves its address/data after grant; the SRAM must not follow.
                drive(cur, 1'b1, w[cur], a[cur] ^ 16'h0FBD, ~d[cur]);
            end
            if (!bus.OE) begin
                oe_cnt++;
                check("oe_is_read", w[cur], 0);
                check("rd_addr", bus.ADDR, a[cur]);
                check("rd_we_high", bus.WE, 1);
                check("rd_grant", bus.grant, cur);
            end
            if (!bus.WE) begin
                we_cnt++;
                check("we_is_write", w[cur], 1);
                check("wr_addr", bus.ADDR, a[cur]);
                check("wr_data", bus.Data_to_SRAM, d[cur]);
                check("wr_oe_high", bus.OE, 1);
                check("wr_grant", bus.grant, cur);
            end
            if (bus.cpu_ack || bus.ld_ack) begin
                check("ack_port", bus.ld_ack ? 1 : 0, cur);
                check("ack_both", bus.cpu_ack & bus.ld_ack, 0);
                check("ack_cycle", c, (W + 1) + served * (W + 2));
                check("strobe_len", w[cur] ? we_cnt : oe_cnt, W);
                check("wrong_strobe", w[cur] ? oe_cnt : we_cnt, 0);
                if (w[cur]) ref_mem[a[cur][7:0]] = d[cur];
                else        exp_rd[cur] = ref_mem[a[cur][7:0]];
                check("cpu_rdata", bus.cpu_rdata, exp_rd[0]);
                check("ld_rdata", bus.ld_rdata, exp_rd[1]);
                last_win = cur;
                drive(cur, 1'b0, w[cur], a[cur], d[cur]);
                served++; oe_cnt = 0; we_cnt = 0;
            end
        end
        if (served < n) begin
            check("ack_timeout", served, n);
            drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
            drive(1, 1'b0, 1'b0, 16'h0, 16'h0);
            repeat (W + 3) @(negedge Clk);
        end
        @(negedge Clk);
        check("ack_pulse_end", {bus.cpu_ack, bus.ld_ack}, 0);
        check("busy_end", bus.busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(8'(i));
        exp_rd[0] = '0; exp_rd[1] = '0;
        last_win  = 1;  // loader counts as last winner out of reset
        drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
        drive(1, 1'b0, 1'b0, 16'h0, 16'h0);

        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            check("rst_strobes", {bus.OE, bus.WE}, 2'b11);
            check("rst_busy_grant", {bus.busy, bus.grant}, 2'b00);
            check("rst_addr_data", {bus.ADDR, bus.Data_to_SRAM}, 32'h0);
            check("rst_acks_rdata", {bus.cpu_ack, bus.ld_ack, bus.cpu_rdata, bus.ld_rdata}, 0);
        end

        // Loader plants 0xBEEF at 0x0042, CPU reads it back (its address moves to 0x0FFF).
        do_round(0, 0, 16'h0, 16'h0, 1, 1, 16'h0042, 16'hBEEF);
        do_round(1, 0, 16'h0042, 16'h0, 0, 0, 16'h0, 16'h0);
        check("cpu_read_beef", bus.cpu_rdata, 16'hBEEF);
        do_round(0, 0, 16'h0, 16'h0, 1, 1, 16'h0100, 16'h1234);
        check("cpu_rdata_kept", bus.cpu_rdata, 16'hBEEF);
        do_round(0, 0, 16'h0, 16'h0, 1, 0, 16'h0100, 16'h0);
        check("ld_read_1234", bus.ld_rdata, 16'h1234);

        // Contention: both ports at once, alternating winners.
        for (int i = 0; i < 4; i++)
            do_round(1, i[0], 16'h0010 + 16'(i), 16'hC000 + 16'(i),
                     1, ~i[0], 16'h0010 + 16'(i), 16'hD000 + 16'(i));

        for (int i = 0; i < 40; i++) begin
            int mode;
            mode = int'($urandom_range(1, 3));
            do_round(mode[0], 1'($urandom), 16'($urandom) & 16'h03FF, 16'($urandom),
                     mode[1], 1'($urandom), 16'($urandom) & 16'h03FF, 16'($urandom));
        end

        // Reset during the second ACCESS cycle of a CPU write.
        @(negedge Clk);
        drive(0, 1'b1, 1'b1, 16'h0033, 16'h7777);
        repeat (2) @(negedge Clk);
        check("abort_we_low", bus.WE, 0);
        Reset = 1'b1;
        #1;
        check("abort_strobes", {bus.OE, bus.WE}, 2'b11);
        check("abort_busy", bus.busy, 0);
        check("abort_acks", {bus.cpu_ack, bus.ld_ack}, 0);
        drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        // The SRAM model latched the write on the edge WE was already low.
        ref_mem[8'h33] = 16'h7777;
        exp_rd[0] = '0; exp_rd[1] = '0;
        last_win  = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge Clk);
            check("post_abort_idle", {bus.cpu_ack, bus.ld_ack, bus.busy}, 0);
        end
        check("post_abort_rdata", bus.cpu_rdata, 0);
        do_round(1, 0, 16'h0033, 16'h0, 0, 0, 16'h0, 16'h0);
        check("post_abort_read", bus.cpu_rdata, 16'h7777);
        do_round(1, 0, 16'h0055, 16'h0, 1, 0, 16'h0056, 16'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Shares the single external SRAM port between the SLC-3 CPU (MAR/MDR memory path) and a second bus master (program loader / DMA), sequencing each access with a fixed number of wait states. Sits between the CPU memory subsystem and the board SRAM pins. It drives the SRAM address, write data and the active-low OE/WE strobes, and returns read data plus a one-cycle acknowledge to the granted requester.

## Interface
- WAIT_CYCLES, 2: cycles OE/WE stay asserted per access; legal range ≥1.
- ADDR_W, 16: address width.
- DATA_W, 16: data width.
- Clk  in  1  single clock, all state on rising edge.
- Reset  in  1  asynchronous, active-high.
- cpu_req  in  1  CPU access request; held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req is high.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_rdata  out  DATA_W  read data, valid when cpu_ack is high.
- cpu_ack  out  1  one-cycle completion pulse.
- ld_req, ld_we, ld_addr, ld_wdata, ld_rdata, ld_ack: loader port, same widths and semantics as the cpu_ signals.
- ADDR  out  ADDR_W  SRAM address.
- Data_to_SRAM  out  DATA_W  SRAM write data.
- Data_from_SRAM  in  DATA_W  SRAM read data.
- OE  out  1  SRAM output enable, active-low.
- WE  out  1  SRAM write enable, active-low.
- busy  out  1  high in every state except IDLE.
- grant  out  1  0 = CPU owns SRAM, 1 = loader; meaningful only while busy.

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE: if any req is high, latch the winner's id, we, addr and wdata into internal registers, load the wait counter with WAIT_CYCLES-1, and go to ACCESS. Otherwise stay in IDLE.
- Arbitration is round-robin. A sole requester wins. If both request, the port not granted last wins. last_grant updates on every grant.
- ACCESS:
  - ADDR is driven from the latched address, Data_to_SRAM from the latched wdata.
  - OE=0 for a read. WE=0 for a write; OE=1 during writes.
  - The counter decrements each cycle. When the counter is 0, Data_from_SRAM is captured into the granted port's rdata register (reads only) and the FSM goes to DONE.
- DONE: pulse the granted port's ack for one cycle, deassert OE/WE, return to IDLE.
- Requester rule: drop req on the edge where ack is sampled high. A req still high in IDLE is treated as a new access.
- Latched address and data shield the SRAM from requester changes after grant. Changes to the non-granted port's signals are ignored until the next IDLE.
- rdata registers hold their last value until the next read on that port. A write does not disturb rdata.
- Counter width is $clog2(WAIT_CYCLES+1).

## Timing
- Reset values:
  - State IDLE; OE=1, WE=1.
  - ADDR=0, Data_to_SRAM=0.
  - Both rdata=0, both ack=0.
  - busy=0, grant=0.
  - last_grant=loader, so the CPU wins the first tie.
- Reset mid-access aborts immediately (asynchronous): strobes return high and no ack is issued.
- All outputs are registered or decoded from registered state only; no combinational path from req to the SRAM pins.
- Latency: req sampled in IDLE at edge t → ACCESS for WAIT_CYCLES cycles → ack high during cycle t+WAIT_CYCLES+1. With WAIT_CYCLES=2, ack arrives 3 cycles after grant.
- Throughput: one access per WAIT_CYCLES+2 cycles. The mandatory IDLE cycle gives bus turnaround between masters.
- Simultaneous new req during ACCESS/DONE: held pending and arbitrated in the next IDLE.

## Structure
- Package sram_arb_pkg holds:
  - typedef enum for the FSM states (IDLE, ACCESS, DONE);
  - typedef enum for port id (PORT_CPU=0, PORT_LD=1);
  - default WAIT_CYCLES constant.
- One sub-module is natural: rr_arb2, a combinational two-input round-robin picker taking (req[1:0], last_grant) and producing a winner id. Everything else lives in sram_arbiter.

## Test plan
- Reset, no requests → OE=WE=1, busy=0, ADDR=0, both acks stay 0 for 20 cycles.
- CPU read at 0x0042 with Data_from_SRAM=0xBEEF, WAIT_CYCLES=2 → OE low for exactly 2 cycles with ADDR=0x0042, WE high; cpu_ack one-cycle pulse 3 cycles after grant; cpu_rdata=0xBEEF.
- Loader write 0x1234 to 0x0100 → WE low 2 cycles, OE high, Data_to_SRAM=0x1234; ld_ack pulse; cpu_rdata unchanged.
- Both request every cycle after reset → grants alternate CPU, loader, CPU, loader; each ack spaced 4 cycles apart; no port starved.
- CPU changes cpu_addr from 0x0042 to 0x0FFF one cycle after grant → ADDR stays 0x0042 for the whole access.
- Reset asserted in the second ACCESS cycle of a write → WE and OE high immediately, no ack; after release, a new CPU read completes normally.
